// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tristate_bus_arbiter
// Description : Round-robin arbiter for a two-source tri-state bus with
//               break-before-make dead time between every release and grant.
//               Optional forced release is enabled by `define ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tristate_bus_arbiter #(
    parameter int DEAD_CYCLES = 2,
    parameter int CNT_W       = 4,
    parameter int HOLD_MAX    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic oe0,
    output logic oe1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic busy,
    output logic to_err
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_own0 = 2'd1;
    localparam logic [1:0] c_own1 = 2'd2;
    localparam logic [1:0] c_dead = 2'd3;

    localparam logic [CNT_W-1:0] c_dead_load = CNT_W'(DEAD_CYCLES - 1);

    generate
        if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15 || DEAD_CYCLES > (1 << CNT_W) ||
            HOLD_MAX < 1 || HOLD_MAX > (1 << CNT_W)) begin : g_bad_params
            $error("tristate_bus_arbiter: DEAD_CYCLES/HOLD_MAX out of range for CNT_W");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_last_owner;
    logic             w_last_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_busy;
    logic             w_arb_en;
    logic             w_req_any;
    logic             w_pick;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             r_to_err;
    logic             w_to_err_nxt;
`endif

    // Tie goes to whichever side did not own the bus last.
    assign w_req_any = req0 | req1;
    assign w_pick    = (req0 & req1) ? ~r_last_owner : req1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last_owner;
        w_sel_nxt   = r_sel;
        w_arb_en    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt   = r_hold;
        w_to_err_nxt = 1'b0;
`endif
        case (r_state)
            c_idle: w_arb_en = 1'b1;
            c_own0: begin
                if (!req0) begin
                    w_state_nxt = c_dead;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = c_dead_load;
                end
`ifdef ARB_TIMEOUT_EN
                else if (req1) begin
                    if (r_hold == c_hold_last) begin
                        w_state_nxt  = c_dead;
                        w_last_nxt   = 1'b0;
                        w_cnt_nxt    = c_dead_load;
                        w_to_err_nxt = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
`endif
            end
            c_own1: begin
                if (!req1) begin
                    w_state_nxt = c_dead;
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = c_dead_load;
                end
`ifdef ARB_TIMEOUT_EN
                else if (req0) begin
                    if (r_hold == c_hold_last) begin
                        w_state_nxt  = c_dead;
                        w_last_nxt   = 1'b1;
                        w_cnt_nxt    = c_dead_load;
                        w_to_err_nxt = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
`endif
            end
            c_dead: begin
                if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
                else             w_arb_en  = 1'b1;
            end
            default: w_state_nxt = c_idle;
        endcase

        if (w_arb_en) begin
            if (w_req_any) begin
                w_state_nxt = w_pick ? c_own1 : c_own0;
                w_sel_nxt   = w_pick;
`ifdef ARB_TIMEOUT_EN
                w_hold_nxt  = '0;
`endif
            end else begin
                w_state_nxt = c_idle;
            end
        end
    end

    // Outputs are registered from the next-state decode so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_cnt        <= '0;
            r_last_owner <= 1'b1;
            r_sel        <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_owner <= w_last_nxt;
            r_sel        <= w_sel_nxt;
            r_gnt0       <= (w_state_nxt == c_own0);
            r_gnt1       <= (w_state_nxt == c_own1);
            r_busy       <= (w_state_nxt != c_idle);
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold   <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_hold   <= w_hold_nxt;
            r_to_err <= w_to_err_nxt;
        end
    end

    assign to_err = r_to_err;
`else
    assign to_err = 1'b0;
`endif

    assign gnt0 = r_gnt0;
    assign gnt1 = r_gnt1;
    assign oe0  = r_gnt0;
    assign oe1  = r_gnt1;
    assign sel  = r_sel;
    assign busy = r_busy;

endmodule
`default_nettype wire
